// File: rtl/grant_index_decoder_pkg.sv
// Shared constants for the grant index decoder: FSM state encoding and
// debug counter width.
package grant_index_decoder_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int DONE_CNT_W = 8;

endpackage : grant_index_decoder_pkg

// File: rtl/grant_index_decoder_hold_timer.sv
// Loadable hold counter: cleared on accept, advanced each unacknowledged
// grant cycle, saturating at HOLD_MAX-1 where it raises its terminal flag.
module hold_timer #(
  parameter int HOLD_MAX = 8,
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic at_max
);

  logic [CNT_W-1:0] count;

  assign at_max = (count == CNT_W'(HOLD_MAX - 1));

  // Saturates rather than wraps so a stuck advance can never alias back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : hold_timer

// File: rtl/grant_index_decoder.sv
// Registered index-to-one-hot grant decoder with ack/timeout release, a
// mandatory dead cycle between grants, and a completed-grant debug counter.
module grant_index_decoder
  import grant_index_decoder_pkg::*;
#(
  parameter int N_OUT    = 4,
  parameter int IDX_W    = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  in_ready,
  input  logic [N_OUT-1:0]      ack,
  output logic [N_OUT-1:0]      grant,
  output logic                  busy,
  output logic                  timeout,
  output logic                  err,
  output logic [DONE_CNT_W-1:0] done_cnt
);

  // Handshake: an index transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE, there is no
  // buffering, so upstream holds in_valid/in_idx stable until it sees ready.

  logic [1:0]       state;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             hit;
  logic             stray;
  logic             expire;
  logic             timer_clear;
  logic             timer_advance;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_ready && in_valid;

  assign hit   = (state == ST_GRANT) && ack[idx_q];
  assign stray = (state == ST_GRANT) ? |(ack & ~grant) : |ack;

  assign timer_clear   = accept;
  assign timer_advance = (state == ST_GRANT) && !hit;

  hold_timer #(
    .HOLD_MAX (HOLD_MAX)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .advance (timer_advance),
    .at_max  (expire)
  );

  // Ack beats expiry on the same edge: the grant counts and no timeout fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx_q    <= '0;
      grant    <= '0;
      timeout  <= 1'b0;
      err      <= 1'b0;
      done_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      err     <= stray;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            idx_q <= in_idx;
            grant <= N_OUT'(1) << in_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (hit) begin
            grant    <= '0;
            done_cnt <= done_cnt + DONE_CNT_W'(1);
            state    <= ST_RELEASE;
          end else if (expire) begin
            grant   <= '0;
            timeout <= 1'b1;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : grant_index_decoder

// File: tb/tb_grant_index_decoder.sv
// Self-checking bench for grant_index_decoder: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_grant_index_decoder;

  localparam int N_OUT    = 4;
  localparam int IDX_W    = 2;
  localparam int HOLD_MAX = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic [N_OUT-1:0] ack;
  logic [N_OUT-1:0] grant;
  logic             busy;
  logic             timeout;
  logic             err;
  logic [7:0]       done_cnt;

  int n_tests;
  int n_fail;
  int exp_done;

  grant_index_decoder #(
    .N_OUT    (N_OUT),
    .IDX_W    (IDX_W),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_idx   (in_idx),
    .in_ready (in_ready),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout),
    .err      (err),
    .done_cnt (done_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done % 256));
  endtask

  // One transaction from IDLE. ack_at: grant cycle (1-based) holding the
  // correct ack, > HOLD_MAX means never. stray_at: cycle with a stray ack on
  // stray_line (0 = none). Called and returns on a falling edge in IDLE.
  task automatic run_txn(input int idx, input int ack_at, input int stray_at, input int stray_line);
    logic [N_OUT-1:0] exp_grant;
    bit acked;
    bit stray_prev;
    check_idle("pre");
    check("pre_err", 32'(err), 32'd0);
    in_valid = 1'b1;
    in_idx   = IDX_W'(idx);
    ack      = '0;
    @(negedge clk);
    in_valid  = 1'b0;
    in_idx    = IDX_W'($urandom_range(0, 3));
    exp_grant = N_OUT'(1 << idx);
    acked      = 1'b0;
    stray_prev = 1'b0;
    for (int c = 1; c <= HOLD_MAX; c++) begin
      check("grant_held", 32'(grant), 32'(exp_grant));
      check("grant_busy", 32'(busy), 32'd1);
      check("grant_ready", 32'(in_ready), 32'd0);
      check("grant_timeout", 32'(timeout), 32'd0);
      check("grant_err", 32'(err), 32'(stray_prev));
      ack = '0;
      stray_prev = 1'b0;
      if (c == stray_at) begin
        ack[stray_line] = 1'b1;
        stray_prev = 1'b1;
      end
      if (c == ack_at) begin
        ack[idx] = 1'b1;
        acked = 1'b1;
      end
      @(negedge clk);
      ack = '0;
      if (acked) break;
    end
    if (acked) exp_done++;
    check("rel_grant", 32'(grant), 32'd0);
    check("rel_busy", 32'(busy), 32'd1);
    check("rel_ready", 32'(in_ready), 32'd0);
    check("rel_timeout", 32'(timeout), 32'(!acked));
    check("rel_err", 32'(err), 32'(stray_prev));
    check("rel_done", 32'(done_cnt), 32'(exp_done % 256));
    @(negedge clk);
    check_idle("post");
    check("post_timeout", 32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_done = 0;
  endtask

  initial begin
    int idx, ack_at, stray_at, stray_line;
    n_tests  = 0;
    n_fail   = 0;
    exp_done = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_idx   = '0;
    ack      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Asynchronous reset mid-grant on line 2.
    in_valid = 1'b1;
    in_idx   = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_grant", 32'(grant), 32'h4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_ready", 32'(in_ready), 32'd1);
    check("async_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_rst");

    // Basic sweep, ack on the second grant cycle.
    for (int i = 0; i < 4; i++) run_txn(i, 2, 0, 0);
    check("sweep_done", 32'(done_cnt), 32'd4);

    // Timeout, then ack/timeout collision on the last grant cycle.
    run_txn(1, HOLD_MAX + 1, 0, 0);
    check("timeout_done", 32'(done_cnt), 32'd4);
    run_txn(0, HOLD_MAX, 0, 0);
    check("collide_done", 32'(done_cnt), 32'd5);

    // Stray ack on line 0 while line 3 is granted, then the correct ack.
    run_txn(3, 3, 1, 0);
    // Stray ack and correct ack on the same edge.
    run_txn(2, 1, 1, 1);

    // Ack while idle is an error and changes nothing else.
    ack = 4'b0100;
    @(negedge clk);
    ack = '0;
    check("idle_err", 32'(err), 32'd1);
    check_idle("idle_stray");
    @(negedge clk);
    check("idle_err_clr", 32'(err), 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      idx        = $urandom_range(0, 3);
      ack_at     = $urandom_range(1, HOLD_MAX + 2);
      stray_at   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, HOLD_MAX) : 0;
      stray_line = (idx + $urandom_range(1, 3)) % 4;
      run_txn(idx, ack_at, stray_at, stray_line);
    end

    // Back-pressure: in_valid held high for 256 immediate-ack transactions.
    do_reset();
    check_idle("bp_start");
    in_valid = 1'b1;
    for (int t = 0; t < 256; t++) begin
      idx = $urandom_range(0, 3);
      check("bp_ready", 32'(in_ready), 32'd1);
      check("bp_done", 32'(done_cnt), 32'(exp_done % 256));
      in_idx = IDX_W'(idx);
      @(negedge clk);
      check("bp_grant", 32'(grant), 32'(1 << idx));
      check("bp_ready_g", 32'(in_ready), 32'd0);
      ack = N_OUT'(1 << idx);
      @(negedge clk);
      ack = '0;
      exp_done++;
      check("bp_rel_grant", 32'(grant), 32'd0);
      check("bp_rel_ready", 32'(in_ready), 32'd0);
      check("bp_rel_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_wrap", 32'(done_cnt), 32'd0);
    @(negedge clk);
    check_idle("bp_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_grant_index_decoder
